// File: rtl/labyrinth_pkg.sv
// Shared direction indices, repeat-FSM state encoding and axis conflict resolution.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package labyrinth_pkg;

   localparam int DIR_UP    = 0;
   localparam int DIR_DOWN  = 1;
   localparam int DIR_LEFT  = 2;
   localparam int DIR_RIGHT = 3;
   localparam int NUM_DIR   = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_HOLD   = 2'b01,
      ST_REPEAT = 2'b10
   } rpt_state_t;

   // Opposing buttons on one axis cancel each other; the other axis is untouched.
   function automatic logic [NUM_DIR-1:0] resolve_axes(input logic [NUM_DIR-1:0] b);
      logic [NUM_DIR-1:0] r;
      r[DIR_UP]    = b[DIR_UP]    & ~b[DIR_DOWN];
      r[DIR_DOWN]  = b[DIR_DOWN]  & ~b[DIR_UP];
      r[DIR_LEFT]  = b[DIR_LEFT]  & ~b[DIR_RIGHT];
      r[DIR_RIGHT] = b[DIR_RIGHT] & ~b[DIR_LEFT];
      return r;
   endfunction

endpackage

// File: rtl/move_strobe_gen_if.sv
// Control/sample inputs and strobe outputs of the movement strobe generator.
// Latency: n/a (wires only).
// Backpressure: none; strobes are fire-and-forget.
interface move_strobe_gen_if #(
   parameter int ACC_W = 9
);
   logic                    en;
   logic                    mode;
   logic [3:0]              btn_in;
   logic signed [ACC_W-1:0] accel_x;
   logic signed [ACC_W-1:0] accel_y;
   logic [3:0]              move;
   logic                    tick;

   modport master (output en, mode, btn_in, accel_x, accel_y, input move, tick);
   modport slave  (input en, mode, btn_in, accel_x, accel_y, output move, tick);
endinterface

// File: rtl/move_repeat_fsm.sv
// Per-direction press/hold/auto-repeat state machine producing a raw strobe request.
// Latency: combinational strobe request; the parent registers it (1 cycle to move).
// Backpressure: none; force_idle or a released button drops to IDLE next cycle.
module move_repeat_fsm
   import labyrinth_pkg::*;
#(
   parameter int REPEAT_DLY = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic force_idle,
   input  logic btn_eff,
   input  logic btn_rise,
   input  logic tick_evt,
   output logic strobe
);

   localparam logic [3:0] HOLD_LAST = 4'(REPEAT_DLY);

   rpt_state_t state_q, state_d;
   logic [3:0] hold_q, hold_d;

   // Next state, hold count and strobe request; release or force_idle wins over everything.
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      strobe  = 1'b0;
      if (force_idle || !btn_eff) begin
         state_d = ST_IDLE;
         hold_d  = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (btn_rise) begin
                  state_d = ST_HOLD;
                  hold_d  = '0;
                  strobe  = 1'b1;
               end
            end
            ST_HOLD: begin
               if (tick_evt) begin
                  hold_d = hold_q + 4'd1;
                  if (hold_d == HOLD_LAST) begin
                     state_d = ST_REPEAT;
                  end
               end
            end
            ST_REPEAT: begin
               strobe = tick_evt;
            end
            default: begin
               state_d = ST_IDLE;
               hold_d  = '0;
            end
         endcase
      end
   end

   // State and hold counter registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
      end
   end

endmodule

// File: rtl/move_strobe_gen.sv
// Tick divider, tilt decode and four repeat FSMs generating movement strobes.
// Latency: 1 cycle from input to move/tick (registered outputs).
// Backpressure: none; en low freezes the divider and idles all outputs.
module move_strobe_gen
   import labyrinth_pkg::*;
#(
   parameter int CLK_HZ      = 100000000,
   parameter int TICK_HZ     = 10,
   parameter int REPEAT_DLY  = 3,
   parameter int ACC_W       = 9,
   parameter int TILT_THRESH = 32
) (
   input  logic               clk,
   input  logic               reset,
   move_strobe_gen_if.slave   bus
);

   localparam int P  = CLK_HZ / TICK_HZ;
   localparam int CW = $clog2(P);
   localparam logic [CW-1:0]          CNT_LAST = CW'(P - 1);
   localparam logic [CW-1:0]          CNT_HALF = CW'(P / 2 - 1);
   localparam logic signed [ACC_W:0]  THR_P    = (ACC_W+1)'(TILT_THRESH);
   localparam logic signed [ACC_W:0]  THR_N    = -THR_P;
   localparam logic [ACC_W:0]         THR_2    = (ACC_W+1)'(2 * TILT_THRESH);

   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 tick_q, tick_d;
   logic [NUM_DIR-1:0]   move_q, move_d;
   logic [NUM_DIR-1:0]   btn_hist_q, btn_hist_d;
   logic                 arm_q, arm_d;
   logic                 mode_q, mode_d;

   logic                 tick_evt, half_evt, mode_chg, force_idle;
   logic [NUM_DIR-1:0]   btn_eff, btn_rise, fsm_strb, tilt_strb;
   logic signed [ACC_W:0] ax, ay;
   logic [ACC_W:0]       mag_x, mag_y;
   logic [NUM_DIR-1:0]   tilt_act, tilt_fast;

   // Divider events, mode-change detection and button edge detection.
   always_comb begin
      cnt_d = cnt_q;
      if (bus.en) begin
         cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      end
      tick_evt   = bus.en & (cnt_q == CNT_LAST);
      half_evt   = bus.en & (cnt_q == CNT_HALF);
      mode_chg   = bus.mode ^ mode_q;
      force_idle = ~bus.en | bus.mode | mode_chg;
      btn_eff    = resolve_axes(bus.btn_in);
      // arm_q blocks a button held across reset release from looking like a fresh press
      btn_rise   = btn_eff & ~btn_hist_q & {NUM_DIR{arm_q}};
      btn_hist_d = btn_eff;
      arm_d      = 1'b1;
      mode_d     = bus.mode;
   end

   // Tilt decode in ACC_W+1 bits so negating the most negative sample cannot wrap.
   always_comb begin
      ax    = {bus.accel_x[ACC_W-1], bus.accel_x};
      ay    = {bus.accel_y[ACC_W-1], bus.accel_y};
      mag_x = ax[ACC_W] ? $unsigned(-ax) : $unsigned(ax);
      mag_y = ay[ACC_W] ? $unsigned(-ay) : $unsigned(ay);
      tilt_act[DIR_RIGHT]  = ax > THR_P;
      tilt_act[DIR_LEFT]   = ax < THR_N;
      tilt_act[DIR_DOWN]   = ay > THR_P;
      tilt_act[DIR_UP]     = ay < THR_N;
      tilt_fast[DIR_RIGHT] = mag_x > THR_2;
      tilt_fast[DIR_LEFT]  = mag_x > THR_2;
      tilt_fast[DIR_DOWN]  = mag_y > THR_2;
      tilt_fast[DIR_UP]    = mag_y > THR_2;
      tilt_strb = tilt_act & ({NUM_DIR{tick_evt}} | (tilt_fast & {NUM_DIR{half_evt}}));
   end

   for (genvar i = 0; i < NUM_DIR; i++) begin : g_dir
      move_repeat_fsm #(
         .REPEAT_DLY (REPEAT_DLY)
      ) u_fsm (
         .clk        (clk),
         .reset      (reset),
         .force_idle (force_idle),
         .btn_eff    (btn_eff[i]),
         .btn_rise   (btn_rise[i]),
         .tick_evt   (tick_evt),
         .strobe     (fsm_strb[i])
      );
   end

   // Output selection: nothing leaves while disabled or on the cycle the mode flips.
   always_comb begin
      move_d = '0;
      if (bus.en && !mode_chg) begin
         move_d = bus.mode ? tilt_strb : fsm_strb;
      end
      tick_d = tick_evt;
   end

   // Registered outputs, divider and history with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q      <= '0;
         tick_q     <= 1'b0;
         move_q     <= '0;
         btn_hist_q <= '0;
         arm_q      <= 1'b0;
         mode_q     <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         tick_q     <= tick_d;
         move_q     <= move_d;
         btn_hist_q <= btn_hist_d;
         arm_q      <= arm_d;
         mode_q     <= mode_d;
      end
   end

   assign bus.move = move_q;
   assign bus.tick = tick_q;

endmodule

// File: tb/tb_move_strobe_gen.sv
// Directed scenarios plus random stimulus checked every cycle against a behavioural model.
// Latency: model predicts outputs one clock after the inputs it sees.
// Backpressure: n/a.
module tb_move_strobe_gen;

   localparam int CLK_HZ = 100;
   localparam int TICK_HZ = 10;
   localparam int P = CLK_HZ / TICK_HZ;
   localparam int RDLY = 3;
   localparam int ACC_W = 9;
   localparam int THR = 32;

   logic clk = 1'b0;
   logic reset;

   move_strobe_gen_if #(.ACC_W(ACC_W)) bus ();

   move_strobe_gen #(
      .CLK_HZ      (CLK_HZ),
      .TICK_HZ     (TICK_HZ),
      .REPEAT_DLY  (RDLY),
      .ACC_W       (ACC_W),
      .TILT_THRESH (THR)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;
   int cyc_n = 0;
   int pulse_cnt [4];
   int tick_log [$];
   int acc_tbl [12] = '{0, 32, 33, -32, -33, 64, 65, -64, -65, 100, -256, 255};

   // reference model state: tick phase, press tracking per direction
   int       m_cnt;
   logic [3:0] m_prev;
   bit       m_armed;
   bit       m_mode;
   bit       m_pressed [4];
   int       m_ticks [4];
   logic [3:0] exp_move;
   logic       exp_tick;

   task automatic model_step();
      logic [3:0] b, eff, bs, ts;
      bit tev, hev, mchg;
      int x, y, mx, my;
      if (!reset) begin
         m_cnt = 0; m_prev = '0; m_armed = 0; m_mode = 0;
         for (int d = 0; d < 4; d++) begin m_pressed[d] = 0; m_ticks[d] = 0; end
         exp_move = '0; exp_tick = 1'b0;
         return;
      end
      tev  = bus.en && (m_cnt == P - 1);
      hev  = bus.en && (m_cnt == P / 2 - 1);
      mchg = (bus.mode != m_mode);
      b = bus.btn_in;
      eff[0] = b[0] & !b[1];
      eff[1] = b[1] & !b[0];
      eff[2] = b[2] & !b[3];
      eff[3] = b[3] & !b[2];
      bs = '0;
      for (int d = 0; d < 4; d++) begin
         if (!bus.en || bus.mode || mchg || !eff[d]) begin
            m_pressed[d] = 0; m_ticks[d] = 0;
         end else if (!m_pressed[d]) begin
            if (!m_prev[d] && m_armed) begin
               m_pressed[d] = 1; m_ticks[d] = 0; bs[d] = 1'b1;
            end
         end else if (tev) begin
            m_ticks[d]++;
            bs[d] = (m_ticks[d] > RDLY);
         end
      end
      x  = int'($signed(bus.accel_x));
      y  = int'($signed(bus.accel_y));
      mx = (x < 0) ? -x : x;
      my = (y < 0) ? -y : y;
      ts[3] = (x > THR)  && (tev || (hev && mx > 2 * THR));
      ts[2] = (x < -THR) && (tev || (hev && mx > 2 * THR));
      ts[1] = (y > THR)  && (tev || (hev && my > 2 * THR));
      ts[0] = (y < -THR) && (tev || (hev && my > 2 * THR));
      exp_move = (bus.en && !mchg) ? (bus.mode ? ts : bs) : 4'b0000;
      exp_tick = tev;
      m_prev  = eff;
      m_armed = 1;
      m_mode  = bus.mode;
      if (bus.en) m_cnt = (m_cnt == P - 1) ? 0 : m_cnt + 1;
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk);
      @(negedge clk);
      cyc_n++;
      n_checks++;
      assert (bus.move === exp_move) else begin
         n_fail++;
         $error("FAIL move cyc=%0d got=%b exp=%b", cyc_n, bus.move, exp_move);
      end
      n_checks++;
      assert (bus.tick === exp_tick) else begin
         n_fail++;
         $error("FAIL tick cyc=%0d got=%b exp=%b", cyc_n, bus.tick, exp_tick);
      end
      for (int d = 0; d < 4; d++) pulse_cnt[d] += int'(bus.move[d]);
      if (bus.tick === 1'b1) tick_log.push_back(cyc_n);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic clear_cnt();
      for (int d = 0; d < 4; d++) pulse_cnt[d] = 0;
   endtask

   task automatic check_int(input string tag, input int got, input int exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   initial begin
      int max_gap;
      reset = 1'b0;
      bus.en = 1'b1; bus.mode = 1'b0; bus.btn_in = 4'b0000;
      bus.accel_x = '0; bus.accel_y = '0;
      clear_cnt();
      run(3);
      reset = 1'b1;

      // single press held then released: 1 press strobe + repeats after 3 ticks
      run(5);
      clear_cnt();
      bus.btn_in = 4'b0001;
      run(80);
      bus.btn_in = 4'b0000;
      run(30);
      check_int("up_hold_strobes", pulse_cnt[0], 6);

      // right+left conflict, down tapped
      clear_cnt();
      bus.btn_in = 4'b1100; run(5);
      bus.btn_in = 4'b1110; run(1);
      bus.btn_in = 4'b1100; run(20);
      bus.btn_in = 4'b0000; run(5);
      check_int("conflict_down_once", pulse_cnt[1], 1);
      check_int("conflict_lr_quiet", pulse_cnt[2] + pulse_cnt[3], 0);

      // tilt mode
      bus.mode = 1'b1; run(5);
      clear_cnt(); bus.accel_x = 9'sd40; run(40);
      check_int("tilt_40_right", pulse_cnt[3], 4);
      clear_cnt(); bus.accel_x = 9'sd70; run(40);
      check_int("tilt_70_right", pulse_cnt[3], 8);
      clear_cnt(); bus.accel_x = -9'sd256; run(40);
      check_int("tilt_m256_left", pulse_cnt[2], 8);
      check_int("tilt_m256_right", pulse_cnt[3], 0);
      clear_cnt(); bus.accel_x = 9'sd32; run(40);
      check_int("tilt_32_none", pulse_cnt[2] + pulse_cnt[3], 0);
      bus.accel_x = '0;

      // reset pulse during repeat
      bus.mode = 1'b0;
      bus.btn_in = 4'b0010; run(50);
      clear_cnt();
      reset = 1'b0; run(1);
      reset = 1'b1; run(25);
      check_int("reset_held_quiet", pulse_cnt[1], 0);
      clear_cnt();
      bus.btn_in = 4'b0000; run(3);
      bus.btn_in = 4'b0010; run(5);
      check_int("reset_repress", pulse_cnt[1], 1);

      // en low for 7 cycles stretches one tick period
      bus.btn_in = 4'b0001;
      tick_log.delete();
      run(12);
      bus.en = 1'b0; run(7);
      bus.en = 1'b1; run(20);
      max_gap = 0;
      for (int i = 1; i < tick_log.size(); i++)
         if (tick_log[i] - tick_log[i-1] > max_gap) max_gap = tick_log[i] - tick_log[i-1];
      check_int("tick_gap_en_low", max_gap, P + 7);

      // mode toggle while up is repeating
      bus.btn_in = 4'b0000; run(1);
      bus.btn_in = 4'b0001; run(40);
      clear_cnt();
      bus.mode = 1'b1; run(3);
      bus.mode = 1'b0; run(30);
      check_int("mode_toggle_quiet", pulse_cnt[0], 0);
      bus.btn_in = 4'b0000; run(3);

      // random stimulus
      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(0, 299) != 0);
         bus.en = bus.en ? ($urandom_range(0, 49) != 0) : ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 99) == 0) bus.mode = ~bus.mode;
         if ($urandom_range(0, 9) == 0) bus.btn_in = bus.btn_in ^ (4'b0001 << $urandom_range(0, 3));
         if ($urandom_range(0, 24) == 0) bus.accel_x = 9'(acc_tbl[$urandom_range(0, 11)]);
         if ($urandom_range(0, 24) == 0) bus.accel_y = 9'(acc_tbl[$urandom_range(0, 11)]);
         cyc();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/move_strobe_gen.md
MOVE_STROBE_GEN -- requirements
Module: move_strobe_gen

Interface
REQ-001 Parameter CLK_HZ, default 100000000, is the system clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 10, is the movement tick rate in Hz; the tick period is P = CLK_HZ/TICK_HZ cycles (integer, P >= 4).
REQ-003 Parameter REPEAT_DLY, default 3, is the number of ticks a button is held before auto-repeat starts (1..15).
REQ-004 Parameter ACC_W, default 9, is the accelerometer sample width (two's complement).
REQ-005 Parameter TILT_THRESH, default 32, is the tilt magnitude threshold (positive, < 2^(ACC_W-2)).
REQ-006 clk  input  1  single system clock; all logic on posedge.
REQ-007 reset  input  1  synchronous, active-low reset.
REQ-008 en  input  1  enable; low freezes the tick counter and forces idle.
REQ-009 mode  input  1  0 = button mode, 1 = tilt mode.
REQ-010 btn_in  input  4  debounced buttons {right, left, down, up}, active high.
REQ-011 accel_x, accel_y  input  ACC_W each  signed tilt samples; +x = right, +y = down.
REQ-012 move  output  4  single-cycle movement strobes {right, left, down, up}; bit order matches btn_in.
REQ-013 tick  output  1  single-cycle strobe once per tick period.

Function
REQ-014 The tick counter SHALL count 0..P-1 while en=1 and wrap to 0; tick SHALL be 1 for exactly the cycle after the counter reaches P-1.
REQ-015 The half-tick event SHALL occur on the cycle the counter reaches P/2-1 (internal only).
REQ-016 Button mode: each direction SHALL have its own FSM with states IDLE, HOLD and REPEAT.
REQ-017 IDLE -> HOLD on a rising edge of the direction's effective button; the move bit SHALL pulse on the next cycle (latency 1), independent of tick.
REQ-018 In HOLD, a 4-bit hold counter SHALL increment on each tick; on reaching REPEAT_DLY -> REPEAT, with no strobe on that tick.
REQ-019 In REPEAT, the move bit SHALL pulse for one cycle per tick, coincident with the tick output.
REQ-020 Release of the effective button SHALL return the FSM to IDLE from any state on the next cycle, clearing its hold counter.
REQ-021 Axis conflict: if both buttons of one axis (right+left or down+up) are high, both effective buttons of that axis SHALL be 0; the other axis is unaffected.
REQ-022 Tilt mode: a direction SHALL be active when the corresponding signed sample exceeds TILT_THRESH in magnitude in that direction; exactly at TILT_THRESH is inactive.
REQ-023 Tilt mode: an active direction SHALL strobe on each tick; if magnitude > 2*TILT_THRESH it SHALL also strobe on each half-tick.
REQ-024 The most negative sample (-2^(ACC_W-1)) SHALL count as beyond 2*TILT_THRESH; magnitude arithmetic SHALL be ACC_W+1 bits wide so it cannot overflow.
REQ-025 A change of mode SHALL force all FSMs to IDLE and suppress all move strobes for that cycle; in button mode, a button already held at the change SHALL NOT produce a strobe until released and pressed again.
REQ-026 en=0 SHALL hold the tick counter, force move=0 and tick=0, and force all FSMs to IDLE; when en returns high, counting SHALL resume from the held value.
REQ-027 At most one strobe SHALL be issued per direction per cycle; simultaneous strobes on different axes are permitted.

Reset
REQ-028 With reset=0 on a clock edge: tick counter=0, all FSMs=IDLE, hold counters=0, button history=0, move=4'b0000, tick=0.
REQ-029 Reset asserted mid-hold or mid-repeat SHALL take effect on the next edge with no residual strobe.
REQ-030 A button held through reset release SHALL produce no strobe until released and pressed again.

Structure
REQ-031 Direction index constants (DIR_UP=0, DIR_DOWN=1, DIR_LEFT=2, DIR_RIGHT=3) and the FSM state encoding SHALL live in a shared package, labyrinth_pkg.
REQ-032 The per-direction FSM SHALL be a sub-module, move_repeat_fsm, instantiated four times; the tick divider and tilt decode stay in move_strobe_gen.

Verification (CLK_HZ=100, TICK_HZ=10, so P=10; REPEAT_DLY=3; TILT_THRESH=32; ACC_W=9)
REQ-033 Button up pressed at cycle 5 and held 80 cycles -> move[0] at cycle 6, none during 3 ticks, then one strobe per tick; release -> no further strobes.
REQ-034 Right+left held together, down tapped -> move[3:2] stay 0; move[1] pulses once.
REQ-035 Tilt mode, accel_x=+40 -> move[3] on every tick; accel_x=+70 -> move[3] every 5 cycles; accel_x=-256 -> move[2] every 5 cycles; accel_x=32 -> none.
REQ-036 Button down held, reset pulsed low for 1 cycle during REPEAT -> outputs 0 next cycle; no strobe until re-press.
REQ-037 en low for 7 cycles mid-period, then mode toggled while up is held -> tick period extended by 7 cycles; no strobe across the mode change.
